// File: rtl/multicycle_control.sv
// multicycle_control: Moore-style sequencer for a shared multicycle MIPS
// datapath (R-type, addi, lw, sw, beq, j). Drives every mux select, write
// enable and the unified memory request, waits on MemReady_i, and flags a
// sticky error on illegal opcodes or memory timeouts.
//
// Optional build macro PERF_COUNT_EN adds RetireCnt_o, a wrapping count of
// instructions that completed normally.
//
// Handshake: MemReq_o (with IorD_o/MemWrite_o) is raised in FETCH, MEMRD and
// MEMWR and held unchanged until the cycle MemReady_i=1, which completes the
// access in that same cycle; MemReady_i is ignored in every other state.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] Op_i,
  input  logic       Zero_i,
  input  logic       MemReady_i,
  output logic       MemReq_o,
  output logic       MemWrite_o,
  output logic       IorD_o,
  output logic       IRWrite_o,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic [1:0] PCSource_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ALUOp_o,
  output logic       RegWrite_o,
  output logic       RegDst_o,
  output logic       MemtoReg_o,
  output logic [3:0] State_o,
  output logic       Err_o
`ifdef PERF_COUNT_EN
  ,
  output logic [31:0] RetireCnt_o
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_wait;
  logic             timeout_hit;

  assign State_o = state_q;
  assign Err_o   = err_q;

  // State, error flag and wait counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, sticky error and wait counter; a timeout overrides the
  // normal transition but a same-cycle MemReady_i always wins.
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    mem_wait    = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    timeout_hit = mem_wait && (MEM_TIMEOUT != 0) && (cnt_q == TO_CNT) && !MemReady_i;
    case (state_q)
      S_FETCH:  if (MemReady_i) state_d = S_DECODE;
      S_DECODE: begin
        case (Op_i)
          OP_RTYPE:     state_d = S_EXEC;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            err_d   = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: state_d = (Op_i == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (MemReady_i) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (MemReady_i) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
    if (timeout_hit) begin
      err_d   = 1'b1;
      state_d = S_FETCH;
    end
    // FETCH->FETCH on timeout is not a state change, so clear explicitly.
    if (!mem_wait || (state_d != state_q) || timeout_hit) begin
      cnt_d = '0;
    end else if (!MemReady_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Moore control outputs per state; FETCH write enables follow MemReady_i
  // and everything is held low while reset is asserted.
  always_comb begin
    MemReq_o      = 1'b0;
    MemWrite_o    = 1'b0;
    IorD_o        = 1'b0;
    IRWrite_o     = 1'b0;
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    PCSource_o    = 2'b00;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    ALUOp_o       = 2'b00;
    RegWrite_o    = 1'b0;
    RegDst_o      = 1'b0;
    MemtoReg_o    = 1'b0;
    if (!rst_i) begin
      case (state_q)
        S_FETCH: begin
          MemReq_o  = 1'b1;
          ALUSrcB_o = 2'b01;
          ALUOp_o   = 2'b01;
          IRWrite_o = MemReady_i;
          PCWrite_o = MemReady_i;
        end
        S_DECODE: begin
          ALUSrcB_o = 2'b11;
          ALUOp_o   = 2'b01;
        end
        S_MEMADR, S_ADDIEX: begin
          ALUSrcA_o = 1'b1;
          ALUSrcB_o = 2'b10;
          ALUOp_o   = 2'b01;
        end
        S_MEMRD: begin
          MemReq_o = 1'b1;
          IorD_o   = 1'b1;
        end
        S_MEMWB: begin
          RegWrite_o = 1'b1;
          MemtoReg_o = 1'b1;
        end
        S_MEMWR: begin
          MemReq_o   = 1'b1;
          MemWrite_o = 1'b1;
          IorD_o     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA_o = 1'b1;
        end
        S_ALUWB: begin
          RegWrite_o = 1'b1;
          RegDst_o   = 1'b1;
        end
        S_ADDIWB: begin
          RegWrite_o = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA_o     = 1'b1;
          ALUOp_o       = 2'b10;
          PCSource_o    = 2'b01;
          PCWriteCond_o = Zero_i;
        end
        S_JUMP: begin
          PCWrite_o  = 1'b1;
          PCSource_o = 2'b10;
        end
        default: begin
          MemReq_o = 1'b0;
        end
      endcase
    end
  end

`ifdef PERF_COUNT_EN
  logic [31:0] retire_q, retire_d;

  assign RetireCnt_o = retire_q;

  // Count normal completions only; error and timeout exits are not retired.
  always_comb begin
    retire_d = retire_q;
    case (state_q)
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retire_d = retire_q + 32'd1;
      S_MEMWR: if (MemReady_i) retire_d = retire_q + 32'd1;
      default: retire_d = retire_q;
    endcase
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) retire_q <= 32'd0;
    else       retire_q <= retire_d;
  end
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM that sequences a shared multicycle MIPS datapath: one ALU, one unified memory port, and IR/A/B/ALUOut/MDR registers.
- Supports R-type, addi, lw, sw, beq and j.
- Sits between the datapath and the ALU-control decoder.
- Drives every mux select, write enable and memory request, and waits on a memory ready handshake.

Parameters:
MEM_TIMEOUT, 255, max wait cycles for MemReady_i per memory access; 0 disables timeout
CNT_W, 8, width of the internal wait counter; must hold MEM_TIMEOUT

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
Op_i  input  6  opcode from IR[31:26]
Zero_i  input  1  ALU zero flag
MemReady_i  input  1  memory completes current request this cycle
MemReq_o  output  1  memory request, held until MemReady_i
MemWrite_o  output  1  request is a write
IorD_o  output  1  address select: 0=PC, 1=ALUOut
IRWrite_o  output  1  load IR
PCWrite_o  output  1  unconditional PC write
PCWriteCond_o  output  1  PC write if Zero_i (gated internally: asserted only when Zero_i=1)
PCSource_o  output  2  00=ALU, 01=ALUOut, 10=jump target
ALUSrcA_o  output  1  0=PC, 1=A
ALUSrcB_o  output  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
ALUOp_o  output  2  00=funct decode, 01=add, 10=sub
RegWrite_o  output  1  register file write
RegDst_o  output  1  0=rt, 1=rd
MemtoReg_o  output  1  0=ALUOut, 1=MDR
State_o  output  4  current state encoding
Err_o  output  1  sticky error: illegal opcode or memory timeout

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Encodings 12-15 are unreachable; if entered, go to FETCH.
- Reset:
  - rst_i sampled high: state<=FETCH, Err_o<=0, wait counter<=0.
  - While rst_i=1, all outputs except State_o and Err_o are forced 0.
- Unlisted outputs are 0 in every state.
- FETCH:
  - MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=01, PCSource=00.
  - IRWrite and PCWrite equal MemReady_i (Mealy).
  - Go to DECODE on MemReady_i; otherwise stay.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=01 (branch target into ALUOut).
  - Next state by Op_i: 000000→EXEC, 001000→ADDIEX, 100011/101011→MEMADR, 000100→BRANCH, 000010→JUMP.
  - Any other opcode: Err_o<=1, go to FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=01. lw→MEMRD, sw→MEMWR.
- MEMRD: MemReq=1, IorD=1. Go to MEMWB on MemReady_i.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Go to FETCH.
- MEMWR: MemReq=1, MemWrite=1, IorD=1. Go to FETCH on MemReady_i.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=00. Go to ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Go to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=01. Go to ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=10, PCSource=01, PCWriteCond=Zero_i. Go to FETCH.
- JUMP: PCWrite=1, PCSource=10. Go to FETCH.
- Latency with zero-wait memory, in cycles: lw 5, R-type/addi/sw 4, beq/j 3.
- Memory handshake:
  - MemReq_o, IorD_o and MemWrite_o are stable until the cycle MemReady_i=1.
  - MemReady_i is ignored outside FETCH/MEMRD/MEMWR.
- Timeout:
  - In FETCH, MEMRD or MEMWR, the wait counter increments each cycle MemReady_i=0 and clears on any state change.
  - If MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT while MemReady_i=0: Err_o<=1, go to FETCH, and no IRWrite/PCWrite/RegWrite is issued.
  - MemReady_i=1 in that same cycle wins; normal completion.
- Err_o is cleared only by reset. Operation continues after an error.

Optional Feature:
- PERF_COUNT_EN defined: add output RetireCnt_o[31:0], reset to 0.
  - Increments by 1, wrapping, on each transition into FETCH from MEMWB, MEMWR (ready), ALUWB, ADDIWB, BRANCH or JUMP.
  - Does not increment on illegal-opcode or timeout exits.
- Undefined: no port and no counter logic.

Test Plan:
- rst_i=1 for 2 cycles mid-lw (state MEMRD) → State_o=0, Err_o=0, MemReq_o=0 while rst_i=1; MemReq_o=1 the cycle after release.
- R-type, MemReady_i always 1 → State_o 0,1,6,7,0; ALUWB cycle shows RegWrite_o=1, RegDst_o=1, MemtoReg_o=0.
- lw, MemReady_i low 3 cycles in FETCH and 2 in MEMRD → MemReq_o held steadily; IRWrite_o pulses once; MEMWB shows RegWrite_o=1, MemtoReg_o=1; total 10 cycles.
- beq with Zero_i=1, then beq with Zero_i=0 → PCWriteCond_o=1 then 0 in BRANCH; PCSource_o=01 and ALUOp_o=10 both times.
- MEM_TIMEOUT=4, sw with MemReady_i held 0 → after 4 wait cycles in MEMWR, State_o=0, Err_o=1, no RegWrite_o; RetireCnt_o unchanged (PERF_COUNT_EN).
- Op_i=6'b111111 → DECODE→FETCH, Err_o=1; following addi completes through ADDIWB, and RetireCnt_o increases by exactly 1.
